// File: rtl/seg_scan_if.sv
// Display port bundle for seg_scan: the value/mode request from upstream and the
// active-low scan outputs going to the LED digits.
interface seg_scan_if;
  // No handshake: seg_data/dec_mode are level signals held by the upstream latch,
  // and any difference from the block's shadow copy is treated as a new request.
  logic [15:0] seg_data;
  logic        dec_mode;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        busy;

  modport master (
    output seg_data, dec_mode,
    input  seg_en, seg_out, busy
  );

  modport slave (
    input  seg_data, dec_mode,
    output seg_en, seg_out, busy
  );
endinterface

// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment driver: 4-digit hex or 5-digit decimal
// (double-dabble conversion), optional leading-zero blanking, registered scan outputs.
module seg_scan #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t          state_q;
  logic            mode_q;
  logic [15:0]     data_q;
  logic [15:0]     shift_q;
  logic [19:0]     bcd_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0][3:0] dig_q;
  logic [7:0]      val_q;
  logic [PW-1:0]   presc_q;
  logic [2:0]      idx_q;
  logic [7:0]      seg_en_q;
  logic [7:0]      seg_out_q;

  logic            chg;
  logic [15:0]     adj_low;
  logic [19:0]     bcd_d;
  logic [4:0]      lz_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hC0;
      4'h1: decode = 8'hF9;
      4'h2: decode = 8'hA4;
      4'h3: decode = 8'hB0;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h92;
      4'h6: decode = 8'h82;
      4'h7: decode = 8'hF8;
      4'h8: decode = 8'h80;
      4'h9: decode = 8'h90;
      4'hA: decode = 8'h88;
      4'hB: decode = 8'h83;
      4'hC: decode = 8'hC6;
      4'hD: decode = 8'hA1;
      4'hE: decode = 8'h86;
      default: decode = 8'h8E;
    endcase
  endfunction

  assign chg = {bus.dec_mode, bus.seg_data} != {mode_q, data_q};

  // The top BCD digit stays <= 3 until the final shift, so it never needs the +3 step.
  always_comb begin
    adj_low = '0;
    for (int i = 0; i < 4; i++) begin
      adj_low[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
    bcd_d = {bcd_q[18:16], adj_low, shift_q[15]};
  end

  always_comb begin
    lz_blank    = '0;
    lz_blank[4] = LZ_SUPPRESS && (bcd_q[19:16] == 4'd0);
    lz_blank[3] = lz_blank[4] && (bcd_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (bcd_q[11:8]  == 4'd0);
    lz_blank[1] = lz_blank[2] && (bcd_q[7:4]   == 4'd0);
  end

  // Conversion FSM; a change event overrides whatever state the FSM is in (abort/restart).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      data_q    <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      dig_q     <= '0;
      val_q     <= '0;
    end else if (chg) begin
      mode_q <= bus.dec_mode;
      data_q <= bus.seg_data;
      if (bus.dec_mode) begin
        shift_q   <= bus.seg_data;
        bcd_q     <= '0;
        bit_cnt_q <= '0;
        state_q   <= S_CONV;
      end else begin
        dig_q   <= {16'h0000, bus.seg_data};
        val_q   <= 8'h0F;
        state_q <= S_IDLE;
      end
    end else begin
      case (state_q)
        S_CONV: begin
          shift_q   <= {shift_q[14:0], 1'b0};
          bcd_q     <= bcd_d;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          dig_q   <= {12'h000, bcd_q};
          val_q   <= {3'b000, ~lz_blank};
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      if (val_q[idx_q]) begin
        seg_en_q  <= ~(8'h01 << idx_q);
        seg_out_q <= decode(dig_q[idx_q]);
      end else begin
        seg_en_q  <= 8'hFF;
        seg_out_q <= 8'hFF;
      end
    end
  end

  assign bus.seg_en  = seg_en_q;
  assign bus.seg_out = seg_out_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (SCAN_DIV = 4): two instances, with and without
// leading-zero blanking, driven with the same inputs.
module tb_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;

  logic [1:0] st_a, st_b;
  logic [7:0] exp_q[$];

  int oh_bad     = 0;
  int busy_hits  = 0;
  int old_hits   = 0;
  bit busy_watch = 1'b0;
  bit old_watch  = 1'b0;

  seg_scan_if ifa();
  seg_scan_if ifb();

  seg_scan #(.SCAN_DIV(4), .LZ_SUPPRESS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .state_o(st_a)
  );
  seg_scan #(.SCAN_DIV(4), .LZ_SUPPRESS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .state_o(st_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- continuous monitors ----------------
  always @(negedge clk) begin
    if (ifa.seg_en != 8'hFF && $countones(~ifa.seg_en) != 1) oh_bad++;
    if (ifb.seg_en != 8'hFF && $countones(~ifb.seg_en) != 1) oh_bad++;
    if (ifa.seg_en == 8'hFF && ifa.seg_out != 8'hFF) oh_bad++;
    if (ifb.seg_en == 8'hFF && ifb.seg_out != 8'hFF) oh_bad++;
    if (busy_watch && ifa.busy) busy_hits++;
    if (old_watch && ifa.seg_en[4:2] != 3'b111) old_hits++;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic m, input logic [15:0] d);
    ifa.dec_mode = m;
    ifa.seg_data = d;
    ifb.dec_mode = m;
    ifb.seg_data = d;
  endtask

  task automatic measure_busy(output int n);
    int guard;
    bit seen, done;
    n = 0; guard = 0; seen = 1'b0; done = 1'b0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
      if (ifa.busy) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_slot0(output int cyc);
    logic [7:0] prev;
    bit hit;
    prev = ifa.seg_en; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ifa.seg_en == 8'hFE && prev != 8'hFE) hit = 1'b1;
      prev = ifa.seg_en;
    end
  endtask

  // Captures one full 32-cycle scan on both instances and compares per slot.
  // Expected vectors are packed {slot7, ..., slot0}; FF means slot never enabled.
  task automatic frame_check(input string tag, input logic [63:0] ea, input logic [63:0] eb);
    logic [7:0] cap_a[8];
    logic [7:0] cap_b[8];
    logic [7:0] sel;
    for (int i = 0; i < 8; i++) begin
      cap_a[i] = 8'hFF;
      cap_b[i] = 8'hFF;
    end
    repeat (32) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        sel = ~(8'h01 << i);
        if (ifa.seg_en == sel) cap_a[i] = ifa.seg_out;
        if (ifb.seg_en == sel) cap_b[i] = ifb.seg_out;
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(ea[8*i +: 8]);
    for (int i = 0; i < 8; i++) exp_q.push_back(eb[8*i +: 8]);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_a_slot%0d", tag, i), cap_a[i], exp_q.pop_front());
    for (int i = 0; i < 8; i++) chk($sformatf("%s_b_slot%0d", tag, i), cap_b[i], exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c, b0, o0;
    drive(1'b0, 16'h0000);
    repeat (3) @(negedge clk);

    chk("rst_seg_en", ifa.seg_en, 8'hFF);
    chk("rst_seg_out", ifa.seg_out, 8'hFF);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_state", st_a, 2'd0);
    rst = 1'b0;

    // All-zero inputs at release: no change event, display stays blank
    busy_watch = 1'b1;
    b0 = busy_hits;
    repeat (2) @(negedge clk);
    frame_check("zero", 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    chk("zero_busy", busy_hits - b0, 0);

    // Hex 1F50: dig0 = 0, dig1 = 5, dig2 = F, dig3 = 1
    b0 = busy_hits;
    drive(1'b0, 16'h1F50);
    @(negedge clk);
    chk("hex_busy_now", ifa.busy, 1'b0);
    @(negedge clk);
    frame_check("hex", 64'hFFFFFFFF_F98E92C0, 64'hFFFFFFFF_F98E92C0);
    chk("hex_busy", busy_hits - b0, 0);
    busy_watch = 1'b0;

    // Scan index wraps every 8 slots * 4 cycles
    wait_slot0(c);
    chk("wrap_align", (c < 200), 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_slot0(c);
      chk($sformatf("wrap_period%0d", k), c, 32);
    end

    // Decimal 65535 -> 6 5 5 3 5
    drive(1'b1, 16'd65535);
    measure_busy(n);
    chk("dec65535_busy", n, 17);
    @(negedge clk);
    frame_check("dec65535", 64'hFFFFFF82_9292B092, 64'hFFFFFF82_9292B092);

    // Decimal 7: leading-zero blanking vs none
    drive(1'b1, 16'd7);
    measure_busy(n);
    chk("dec7_busy", n, 17);
    @(negedge clk);
    frame_check("dec7", 64'hFFFFFFFF_FFFFFFF8, 64'hFFFFFFC0_C0C0C0F8);

    // Abort: 12345 replaced by 42 mid-conversion; slots 2..4 must never light on dut_a
    o0 = old_hits;
    old_watch = 1'b1;
    drive(1'b1, 16'd12345);
    repeat (8) @(negedge clk);
    chk("abort_busy_mid", ifa.busy, 1'b1);
    drive(1'b1, 16'd42);
    measure_busy(n);
    chk("abort_busy", n, 17);
    @(negedge clk);
    frame_check("abort42", 64'hFFFFFFFF_FFFF99A4, 64'hFFFFFFC0_C0C099A4);
    old_watch = 1'b0;
    chk("abort_no_old", old_hits - o0, 0);

    // Reset mid-conversion, timed so slot 1 of "42" is being displayed
    wait_slot0(c);
    chk("rstc_align", (c < 200), 1'b1);
    drive(1'b1, 16'd1234);
    repeat (5) @(negedge clk);
    chk("rstc_pre_en", ifa.seg_en, 8'hFD);
    chk("rstc_pre_busy", ifa.busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstc_seg_en", ifa.seg_en, 8'hFF);
    chk("rstc_seg_out", ifa.seg_out, 8'hFF);
    chk("rstc_busy", ifa.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    measure_busy(n);
    chk("rstc_busy_len", n, 17);
    @(negedge clk);
    frame_check("dec1234", 64'hFFFFFFFF_F9A4B099, 64'hFFFFFFC0_F9A4B099);

    // Abort into hex mode: conversion dropped, hex commit takes effect next edge
    drive(1'b1, 16'd9999);
    repeat (4) @(negedge clk);
    chk("habort_busy_mid", ifa.busy, 1'b1);
    drive(1'b0, 16'h00AB);
    @(negedge clk);
    chk("habort_busy", ifa.busy, 1'b0);
    @(negedge clk);
    frame_check("hexAB", 64'hFFFFFFFF_C0C08883, 64'hFFFFFFFF_C0C08883);

    chk("onehot", oh_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
